color_meas_ctrl: RTL and testbench

COLOR_MEAS_CTRL -- requirements
Module: color_meas_ctrl

---
 rtl/color_meas_ctrl_pkg.sv | 19 +
 rtl/color_meas_ctrl_if.sv | 25 ++
 rtl/color_meas_ctrl_edge_sync.sv | 25 ++
 rtl/color_meas_ctrl.sv | 144 ++++++++++++++
 tb/tb_color_meas_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/color_meas_ctrl_pkg.sv
// rtl/color_meas_ctrl_pkg.sv - shared FSM encoding and default sizing for the color meter
package color_meas_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS,
    ST_DIV,
    ST_BCD,
    ST_HOLD
  } state_t;

  localparam int DEF_PERIODS = 4;
  localparam int DEF_CNT_W   = 14;
  localparam int DEF_TMO     = 16383;
  localparam int FREQ_W      = 9;
  localparam int DIGS_W      = 12;

endpackage

// File: rtl/color_meas_ctrl_if.sv
// rtl/color_meas_ctrl_if.sv - divider and BCD converter handshake bundle
interface color_meas_ctrl_if
  import color_meas_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic              div_start;
  logic [CNT_W-1:0]  div_period;
  logic              div_done;
  logic [FREQ_W-1:0] div_freq;
  logic              bcd_start;
  logic [FREQ_W-1:0] bcd_freq;
  logic              bcd_done;
  logic [DIGS_W-1:0] bcd_digs;

  modport master (
    output div_start, div_period, bcd_start, bcd_freq,
    input  div_done, div_freq, bcd_done, bcd_digs
  );

  modport slave (
    input  div_start, div_period, bcd_start, bcd_freq,
    output div_done, div_freq, bcd_done, bcd_digs
  );
endinterface

// File: rtl/color_meas_ctrl_edge_sync.sv
// rtl/color_meas_ctrl_edge_sync.sv - two-flop synchronizer with rising-edge strobe
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/color_meas_ctrl.sv
// rtl/color_meas_ctrl.sv - times PERIODS color periods in ticks, drives divider and BCD
// converter, and publishes the digits on each display update.
module color_meas_ctrl
  import color_meas_ctrl_pkg::*;
#(
  parameter int PERIODS = DEF_PERIODS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMO     = DEF_TMO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              upd,
  input  logic              color,
  color_meas_ctrl_if.master hs,
  output logic [DIGS_W-1:0] digs,
  output logic              valid,
  output logic              no_sig
);
  localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TMO);
  localparam logic [3:0]       PERIODS_C = 4'(PERIODS);

  state_t            state_q;
  logic [CNT_W-1:0]  tick_cnt_q;
  logic [3:0]        edge_cnt_q;
  logic              div_start_q;
  logic [CNT_W-1:0]  div_period_q;
  logic              bcd_start_q;
  logic [FREQ_W-1:0] bcd_freq_q;
  logic [DIGS_W-1:0] pend_digs_q;
  logic              pend_ns_q;
  logic [DIGS_W-1:0] digs_q;
  logic              valid_q;
  logic              no_sig_q;

  logic              rise;
  logic [CNT_W-1:0]  tick_cnt_d;
  logic [3:0]        edge_cnt_d;
  logic              timeout;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(color),
    .rise_o (rise)
  );

  // Saturating count: the tick of the current clk is included, so a tick that
  // coincides with the final edge still lands in div_period.
  assign tick_cnt_d = (tick && (tick_cnt_q != TMO_C)) ? tick_cnt_q + 1'b1 : tick_cnt_q;
  assign edge_cnt_d = edge_cnt_q + 4'd1;
  assign timeout    = (tick_cnt_q == TMO_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      div_start_q  <= 1'b0;
      div_period_q <= '0;
      bcd_start_q  <= 1'b0;
      bcd_freq_q   <= '0;
      pend_digs_q  <= '0;
      pend_ns_q    <= 1'b0;
      digs_q       <= '0;
      valid_q      <= 1'b0;
      no_sig_q     <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      bcd_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tick_cnt_q <= '0;
          edge_cnt_q <= '0;
          state_q    <= ST_ARM;
        end
        ST_ARM: begin
          if (timeout) begin
            pend_digs_q <= '0;
            pend_ns_q   <= 1'b1;
            state_q     <= ST_HOLD;
          end else if (rise) begin
            tick_cnt_q <= '0;
            edge_cnt_q <= '0;
            state_q    <= ST_MEAS;
          end else begin
            tick_cnt_q <= tick_cnt_d;
          end
        end
        ST_MEAS: begin
          if (timeout) begin
            pend_digs_q <= '0;
            pend_ns_q   <= 1'b1;
            state_q     <= ST_HOLD;
          end else begin
            tick_cnt_q <= tick_cnt_d;
            if (rise) begin
              edge_cnt_q <= edge_cnt_d;
              if (edge_cnt_d == PERIODS_C) begin
                div_period_q <= tick_cnt_d;
                div_start_q  <= 1'b1;
                state_q      <= ST_DIV;
              end
            end
          end
        end
        // A done seen while our own start is still on the wire cannot belong to it.
        ST_DIV: begin
          if (hs.div_done && !div_start_q) begin
            bcd_freq_q  <= hs.div_freq;
            bcd_start_q <= 1'b1;
            state_q     <= ST_BCD;
          end
        end
        ST_BCD: begin
          if (hs.bcd_done && !bcd_start_q) begin
            pend_digs_q <= hs.bcd_digs;
            pend_ns_q   <= 1'b0;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (upd) begin
            digs_q     <= pend_digs_q;
            no_sig_q   <= pend_ns_q;
            valid_q    <= 1'b1;
            tick_cnt_q <= '0;
            edge_cnt_q <= '0;
            state_q    <= ST_ARM;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hs.div_start  = div_start_q;
  assign hs.div_period = div_period_q;
  assign hs.bcd_start  = bcd_start_q;
  assign hs.bcd_freq   = bcd_freq_q;
  assign digs          = digs_q;
  assign valid         = valid_q;
  assign no_sig        = no_sig_q;
endmodule

// File: tb/tb_color_meas_ctrl.sv
// tb/tb_color_meas_ctrl.sv - scoreboard bench for color_meas_ctrl with divider/BCD models
module tb_color_meas_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic upd = 1'b0;
  logic color = 1'b0;
  logic [11:0] digs;
  logic valid;
  logic no_sig;

  color_meas_ctrl_if #(.CNT_W(14)) hs ();

  color_meas_ctrl #(.PERIODS(4), .CNT_W(14), .TMO(200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .upd   (upd),
    .color (color),
    .hs    (hs),
    .digs  (digs),
    .valid (valid),
    .no_sig(no_sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] digs;
    logic        valid;
    logic        no_sig;
  } disp_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    div_cnt = 0;
  int    bcd_cnt = 0;
  int    cyc = 0;
  int    tick_ph = 7;
  bit    color_on = 0;
  logic [8:0]  div_ret = '0;
  logic [11:0] bcd_ret = '0;
  int    div_q[$];
  int    bcd_q[$];
  disp_t disp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Inputs follow a 10-clk tick grid and a 100-clk color period, both indexed by cyc.
  task automatic step();
    @(posedge clk);
    #1;
    tick  = ((cyc % 10) == tick_ph);
    color = color_on && ((cyc % 100) < 50);
    upd   = 1'b0;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_upd(input logic [11:0] d, input logic v, input logic ns);
    disp_t e;
    e.digs = d; e.valid = v; e.no_sig = ns;
    disp_q.push_back(e);
    step();
    upd = 1'b1;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digs"}, 32'(digs), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_no_sig"}, 32'(no_sig), 0);
    chk({tag, "_div_start"}, 32'(hs.div_start), 0);
    chk({tag, "_bcd_start"}, 32'(hs.bcd_start), 0);
    chk({tag, "_div_period"}, 32'(hs.div_period), 0);
    chk({tag, "_bcd_freq"}, 32'(hs.bcd_freq), 0);
  endtask

  task automatic start_color(input int ph);
    tick_ph  = ph;
    cyc      = 0;
    color_on = 1;
  endtask

  // Divider model: done 20 clks after start, independent of reset.
  initial begin
    hs.div_done = 1'b0;
    hs.div_freq = '0;
    forever begin
      @(negedge clk);
      if (hs.div_start === 1'b1) begin
        repeat (20) @(posedge clk);
        #1 hs.div_done = 1'b1; hs.div_freq = div_ret;
        @(posedge clk);
        #1 hs.div_done = 1'b0;
      end
    end
  end

  initial begin
    hs.bcd_done = 1'b0;
    hs.bcd_digs = '0;
    forever begin
      @(negedge clk);
      if (hs.bcd_start === 1'b1) begin
        repeat (5) @(posedge clk);
        #1 hs.bcd_done = 1'b1; hs.bcd_digs = bcd_ret;
        @(posedge clk);
        #1 hs.bcd_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a start or a display update.
  initial begin
    bit upd_pend = 0;
    bit prev_start = 0;
    bit start_now;
    disp_t e;
    forever begin
      @(negedge clk);
      if (upd_pend) begin
        upd_pend = 0;
        if (disp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL disp_unexpected: got update, required none queued");
        end else begin
          e = disp_q.pop_front();
          chk("digs", 32'(digs), 32'(e.digs));
          chk("valid", 32'(valid), 32'(e.valid));
          chk("no_sig", 32'(no_sig), 32'(e.no_sig));
        end
      end
      if (upd === 1'b1) upd_pend = 1;
      start_now = (hs.div_start === 1'b1) || (hs.bcd_start === 1'b1);
      if (start_now) chk("start_back_to_back", 32'(prev_start), 0);
      prev_start = start_now;
      if (hs.div_start === 1'b1) begin
        div_cnt++;
        if (div_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL div_start_unexpected: got pulse with period %0d, required none", hs.div_period);
        end else chk("div_period", 32'(hs.div_period), 32'(div_q.pop_front()));
      end
      if (hs.bcd_start === 1'b1) begin
        bcd_cnt++;
        if (bcd_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL bcd_start_unexpected: got pulse with freq %0d, required none", hs.bcd_freq);
        end else chk("bcd_freq", 32'(hs.bcd_freq), 32'(bcd_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    int c0;
    int w;
    steps(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    steps(5);

    // Nominal measurement, with an upd landing mid-window that must not publish.
    div_ret = 9'd250; bcd_ret = 12'h250;
    div_q.push_back(40); bcd_q.push_back(250);
    start_color(7);
    steps(250);
    do_upd(12'h000, 1'b0, 1'b0);
    steps(450);
    color_on = 0;
    steps(5);
    do_upd(12'h250, 1'b1, 1'b0);
    chk("a_div_cnt", 32'(div_cnt), 1);
    chk("a_bcd_cnt", 32'(bcd_cnt), 1);

    // No signal: TMO=200 ticks of 10 clks.
    steps(2100);
    do_upd(12'h000, 1'b1, 1'b1);
    chk("b_div_cnt", 32'(div_cnt), 1);
    chk("b_bcd_cnt", 32'(bcd_cnt), 1);

    // Final edge coincident with a tick.
    div_ret = 9'd100; bcd_ret = 12'h100;
    div_q.push_back(40); bcd_q.push_back(100);
    start_color(2);
    steps(700);
    color_on = 0;
    steps(5);
    do_upd(12'h100, 1'b1, 1'b0);
    chk("c_div_cnt", 32'(div_cnt), 2);
    chk("c_bcd_cnt", 32'(bcd_cnt), 2);

    // Reset during DIV; the late div_done must be ignored.
    div_ret = 9'd55;
    div_q.push_back(40);
    start_color(7);
    c0 = div_cnt;
    w = 0;
    while (div_cnt == c0 && w < 1000) begin step(); w++; end
    chk("d_div_seen", 32'(div_cnt), 32'(c0 + 1));
    steps(3);
    color_on = 0;
    rst_n = 1'b0;
    step();
    chk_reset_outputs("d_rst");
    steps(3);
    rst_n = 1'b1;
    steps(40);
    chk("d_bcd_cnt", 32'(bcd_cnt), 2);
    chk("d_digs", 32'(digs), 0);
    chk("d_valid", 32'(valid), 0);
    chk("d_no_sig", 32'(no_sig), 0);

    // Controller restarts cleanly after the abandoned measurement.
    div_ret = 9'd7; bcd_ret = 12'h007;
    div_q.push_back(40); bcd_q.push_back(7);
    start_color(7);
    steps(700);
    color_on = 0;
    steps(5);
    do_upd(12'h007, 1'b1, 1'b0);
    steps(5);
    chk("e_div_cnt", 32'(div_cnt), 4);
    chk("e_bcd_cnt", 32'(bcd_cnt), 3);
    chk("div_q_left", 32'(div_q.size()), 0);
    chk("bcd_q_left", 32'(bcd_q.size()), 0);
    chk("disp_q_left", 32'(disp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
